// File: rtl/conv2_stream_loader.sv
// Streams image, weights and biases from a shared parameter memory into conv_layer_2.
// Optional macro CONV2_LOADER_CHECKSUM_EN adds a 32-bit running sum of transmitted beats.
module conv2_stream_loader #(
    parameter int IN_CHANNELS  = 2,
    parameter int OUT_CHANNELS = 3,
    parameter int IN_IMG_SIZE  = 12,
    parameter int KERNEL_SIZE  = 3,
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_start,
    input  logic                  hold,
    output logic                  busy,
    output logic                  load_done,
    output logic                  mem_rd_en,
    output logic [1:0]            mem_sel,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
`ifdef CONV2_LOADER_CHECKSUM_EN
    output logic [31:0]           checksum,
`endif
    output logic                  start_conv2,
    output logic                  data_valid,
    output logic [DATA_WIDTH-1:0] partial_image_in,
    output logic [DATA_WIDTH-1:0] partial_weights_in,
    output logic [DATA_WIDTH-1:0] partial_biases_in
);

    localparam int TOTAL_PIXELS  = IN_IMG_SIZE * IN_IMG_SIZE * IN_CHANNELS;
    localparam int TOTAL_WEIGHTS = KERNEL_SIZE * KERNEL_SIZE * IN_CHANNELS * OUT_CHANNELS;
    localparam int TOTAL_BIASES  = OUT_CHANNELS;

    localparam logic [ADDR_WIDTH-1:0] LAST_IMG  = ADDR_WIDTH'(TOTAL_PIXELS - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_WGT  = ADDR_WIDTH'(TOTAL_WEIGHTS - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_BIAS = ADDR_WIDTH'(TOTAL_BIASES - 1);

    localparam logic [1:0] SEL_IMG  = 2'b00;
    localparam logic [1:0] SEL_WGT  = 2'b01;
    localparam logic [1:0] SEL_BIAS = 2'b10;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_IMG   = 3'd2;
    localparam logic [2:0] S_WGT   = 3'd3;
    localparam logic [2:0] S_BIAS  = 3'd4;
    localparam logic [2:0] S_DRAIN = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            sel_q, sel_d;
    logic                  rd_pend_q, rd_pend_d;
    logic [1:0]            tag_q, tag_d;
    logic                  valid_q, valid_d;
    logic                  issue;
    logic [ADDR_WIDTH-1:0] region_last;

    always_comb begin
        case (sel_q)
            SEL_WGT:  region_last = LAST_WGT;
            SEL_BIAS: region_last = LAST_BIAS;
            default:  region_last = LAST_IMG;
        endcase
    end

    // START issues the first image read itself, so it shares the streaming branch.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        sel_d   = sel_q;
        issue   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (load_start) begin
                    state_d = S_START;
                    addr_d  = '0;
                    sel_d   = SEL_IMG;
                end
            end
            S_START, S_IMG, S_WGT, S_BIAS: begin
                if (state_q == S_START) begin
                    state_d = S_IMG;
                end
                if (!hold) begin
                    issue = 1'b1;
                    if (addr_q == region_last) begin
                        addr_d = '0;
                        case (sel_q)
                            SEL_IMG: begin
                                state_d = S_WGT;
                                sel_d   = SEL_WGT;
                            end
                            SEL_WGT: begin
                                state_d = S_BIAS;
                                sel_d   = SEL_BIAS;
                            end
                            default: begin
                                state_d = S_DRAIN;
                                sel_d   = SEL_IMG;
                            end
                        endcase
                    end else begin
                        addr_d = addr_q + ADDR_WIDTH'(1);
                    end
                end
            end
            // The last beat is being registered when no read is outstanding.
            S_DRAIN: begin
                if (!rd_pend_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rd_pend_d = issue;
        tag_d     = sel_q;
        valid_d   = rd_pend_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            sel_q     <= SEL_IMG;
            rd_pend_q <= 1'b0;
            tag_q     <= SEL_IMG;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            sel_q     <= sel_d;
            rd_pend_q <= rd_pend_d;
            tag_q     <= tag_d;
            valid_q   <= valid_d;
        end
    end

    // One output register per region; only the tagged one captures the returning word.
    for (genvar gi = 0; gi < 3; gi++) begin : g_word
        logic [DATA_WIDTH-1:0] word_q, word_d;

        always_comb begin
            word_d = word_q;
            if (rd_pend_q && (tag_q == 2'(gi))) begin
                word_d = mem_rd_data;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                word_q <= '0;
            end else begin
                word_q <= word_d;
            end
        end
    end

`ifdef CONV2_LOADER_CHECKSUM_EN
    logic [31:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (state_q == S_START) begin
            checksum_d = '0;
        end else if (rd_pend_q) begin
            checksum_d = checksum_q + 32'($signed(mem_rd_data));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`endif

    assign busy               = (state_q != S_IDLE);
    assign load_done          = (state_q == S_DONE);
    assign start_conv2        = (state_q == S_START);
    assign mem_rd_en          = issue;
    assign mem_sel            = sel_q;
    assign mem_addr           = addr_q;
    assign data_valid         = valid_q;
    assign partial_image_in   = g_word[0].word_q;
    assign partial_weights_in = g_word[1].word_q;
    assign partial_biases_in  = g_word[2].word_q;

endmodule

// File: tb/tb_conv2_stream_loader.sv
// Randomised self-checking bench for conv2_stream_loader against a stream-level reference model.
module tb_conv2_stream_loader;

    localparam int NPIX   = 288;
    localparam int NWGT   = 54;
    localparam int NBIAS  = 3;
    localparam int NBEATS = NPIX + NWGT + NBIAS;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_start;
    logic        hold;
    logic        busy, load_done, mem_rd_en, start_conv2, data_valid;
    logic [1:0]  mem_sel;
    logic [8:0]  mem_addr;
    logic [15:0] mem_rd_data;
    logic [15:0] partial_image_in, partial_weights_in, partial_biases_in;
    logic [31:0] checksum;

    logic        ls2;
    logic        hold2 = 1'b0;
    logic        busy2, done2, rd_en2, start2, dv2;
    logic [1:0]  sel2;
    logic [8:0]  addr2;
    logic [15:0] rd2, img2, wgt2, bias2;
    logic [31:0] checksum2;

    always #5 clk = ~clk;

    conv2_stream_loader dut (
        .clk(clk), .reset(reset), .load_start(load_start), .hold(hold),
        .busy(busy), .load_done(load_done), .mem_rd_en(mem_rd_en),
        .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
`ifdef CONV2_LOADER_CHECKSUM_EN
        .checksum(checksum),
`endif
        .start_conv2(start_conv2), .data_valid(data_valid),
        .partial_image_in(partial_image_in), .partial_weights_in(partial_weights_in),
        .partial_biases_in(partial_biases_in)
    );

    conv2_stream_loader #(
        .IN_CHANNELS(1), .OUT_CHANNELS(1), .IN_IMG_SIZE(4), .KERNEL_SIZE(3)
    ) dut_small (
        .clk(clk), .reset(reset), .load_start(ls2), .hold(hold2),
        .busy(busy2), .load_done(done2), .mem_rd_en(rd_en2),
        .mem_sel(sel2), .mem_addr(addr2), .mem_rd_data(rd2),
`ifdef CONV2_LOADER_CHECKSUM_EN
        .checksum(checksum2),
`endif
        .start_conv2(start2), .data_valid(dv2),
        .partial_image_in(img2), .partial_weights_in(wgt2),
        .partial_biases_in(bias2)
    );

`ifndef CONV2_LOADER_CHECKSUM_EN
    assign checksum  = 32'd0;
    assign checksum2 = 32'd0;
`endif

    // Parameter memory models
    logic [15:0] img_m  [512];
    logic [15:0] wgt_m  [512];
    logic [15:0] bias_m [512];

    always @(posedge clk) begin
        if (mem_rd_en) begin
            case (mem_sel)
                2'b00:   mem_rd_data <= img_m[mem_addr];
                2'b01:   mem_rd_data <= wgt_m[mem_addr];
                default: mem_rd_data <= bias_m[mem_addr];
            endcase
        end
    end

    function automatic logic [15:0] pat(input logic [1:0] s, input logic [8:0] a);
        case (s)
            2'b00:   return 16'(a);
            2'b01:   return 16'h1000 + 16'(a);
            default: return 16'h2000 + 16'(a);
        endcase
    endfunction

    always @(posedge clk) begin
        if (rd_en2) rd2 <= pat(sel2, addr2);
    end

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Shared state between driver and monitor
    logic [17:0] exp_q[$];
    logic [31:0] exp_csum;
    logic [15:0] saved[3];
    bit          in_load = 1'b0;
    int          k_edge = 0;
    int          start_cnt, start_rel, done_cnt, done_rel, beat_cnt, first_beat_rel;

    // Monitor: every cycle, outputs compared to the stream model
    initial begin
        int rel;
        logic [17:0] e;
        bit h1, h2;
        h1 = 0; h2 = 0;
        saved[0] = '0; saved[1] = '0; saved[2] = '0;
        forever begin
            @(negedge clk);
            rel = cyc - k_edge + 1;
            if (reset) begin
                check("rst_ctrl", {27'd0, busy, load_done, mem_rd_en, start_conv2, data_valid}, 32'd0);
                check("rst_sel_addr", {21'd0, mem_sel, mem_addr}, 32'd0);
                check("rst_img", {16'd0, partial_image_in}, 32'd0);
                check("rst_wgt", {16'd0, partial_weights_in}, 32'd0);
                check("rst_bias", {16'd0, partial_biases_in}, 32'd0);
                check("rst_checksum", checksum, 32'd0);
                saved[0] = '0; saved[1] = '0; saved[2] = '0;
                exp_q.delete();
                in_load = 1'b0;
            end else begin
                check("busy", {31'd0, busy}, {31'd0, in_load});
                if (start_conv2) begin
                    start_cnt++;
                    start_rel = rel;
                end
                if (data_valid) begin
                    check("dv_vs_hold", {31'd0, h2}, 32'd0);
                    if (first_beat_rel < 0) first_beat_rel = rel;
                    beat_cnt++;
                    if (exp_q.size() == 0) begin
                        check("extra_beat", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        saved[e[17:16]] = e[15:0];
                    end
                end
                check("img_port", {16'd0, partial_image_in}, {16'd0, saved[0]});
                check("wgt_port", {16'd0, partial_weights_in}, {16'd0, saved[1]});
                check("bias_port", {16'd0, partial_biases_in}, {16'd0, saved[2]});
                if (load_done) begin
                    done_cnt++;
                    done_rel = rel;
                    check("done_all_sent", exp_q.size(), 32'd0);
`ifdef CONV2_LOADER_CHECKSUM_EN
                    check("checksum", checksum, exp_csum);
`endif
                    in_load = 1'b0;
                end
            end
            h2 = h1;
            h1 = hold;
        end
    end

    task automatic fill_mem(input bit rnd);
        for (int i = 0; i < 512; i++) begin
            img_m[i]  = rnd ? 16'($urandom) : pat(2'b00, 9'(i));
            wgt_m[i]  = rnd ? 16'($urandom) : pat(2'b01, 9'(i));
            bias_m[i] = rnd ? 16'($urandom) : pat(2'b10, 9'(i));
        end
    endtask

    // mode: 0 free-running, 1 five-cycle hold, 2 stray load_start, 3 random, 4 reset in weights
    task automatic run_load(input int mode, input int lit_done);
        int exp_done;
        int nz;
        logic [31:0] cs;
        exp_done = -1;
        nz = 0;
        cs = 0;
        exp_q.delete();
        for (int i = 0; i < NPIX; i++) begin
            exp_q.push_back({2'b00, img_m[i]});
            cs += 32'($signed(img_m[i]));
        end
        for (int i = 0; i < NWGT; i++) begin
            exp_q.push_back({2'b01, wgt_m[i]});
            cs += 32'($signed(wgt_m[i]));
        end
        for (int i = 0; i < NBIAS; i++) begin
            exp_q.push_back({2'b10, bias_m[i]});
            cs += 32'($signed(bias_m[i]));
        end
        exp_csum = cs;
        start_cnt = 0; done_cnt = 0; beat_cnt = 0;
        first_beat_rel = -1; done_rel = -1; start_rel = -1;
        load_start = 1'b1;
        @(posedge clk);
        #1;
        k_edge = cyc;
        load_start = 1'b0;
        in_load = 1'b1;
        for (int r = 1; r <= 1500; r++) begin
            hold = 1'b0;
            load_start = 1'b0;
            case (mode)
                1: hold = (r >= 100 && r <= 104);
                2: load_start = (r == 50 || r == 200 || r == 348);
                3: begin
                    hold = ($urandom_range(0, 3) == 0);
                    load_start = (r <= 340) && ($urandom_range(0, 40) == 0);
                end
                4: reset = (r == 300 || r == 301);
                default: ;
            endcase
            if (!hold && nz < NBEATS) begin
                nz++;
                if (nz == NBEATS) exp_done = r + 3;
            end
            @(posedge clk);
            #1;
            if (done_cnt > 0) break;
            if (mode == 4 && r == 305) break;
        end
        hold = 1'b0;
        load_start = 1'b0;
        if (mode != 4) begin
            check("busy_after_done", {31'd0, busy}, 32'd0);
            check("start_count", start_cnt, 32'd1);
            check("start_rel", start_rel, 32'd1);
            check("beat_count", beat_cnt, NBEATS);
            check("done_count", done_cnt, 32'd1);
            check("done_rel_model", done_rel, exp_done);
            if (lit_done > 0) begin
                check("done_rel_literal", done_rel, lit_done);
                check("first_beat_rel", first_beat_rel, 32'd3);
            end
            $display("load mode %0d: beats=%0d start@%0d done@%0d", mode, beat_cnt, start_rel, done_rel);
        end else begin
            check("no_done_after_reset", done_cnt, 32'd0);
            $display("load mode 4: reset after %0d beats", beat_cnt);
        end
    endtask

    initial begin
        int n;
        int d2rel;
        logic [15:0] want;
        logic [15:0] got;
        reset = 1'b1;
        load_start = 1'b0;
        hold = 1'b0;
        ls2 = 1'b0;
        fill_mem(1'b0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        run_load(0, 348);
        check("last_img_lit", {16'd0, partial_image_in}, 32'h0000_011F);
        check("last_wgt_lit", {16'd0, partial_weights_in}, 32'h0000_1035);
        check("last_bias_lit", {16'd0, partial_biases_in}, 32'h0000_2002);
        check("model_csum_lit", exp_csum, 32'h0004_670A);
`ifdef CONV2_LOADER_CHECKSUM_EN
        check("checksum_lit", checksum, 32'h0004_670A);
`endif
        run_load(1, 353);
        run_load(2, 348);
        run_load(4, 0);
        run_load(0, 348);

        fill_mem(1'b1);
        for (int i = 0; i < 3; i++) run_load(3, 0);

        // Reduced-parameter instance: 16 + 9 + 1 beats
        n = 0;
        d2rel = -1;
        ls2 = 1'b1;
        @(posedge clk);
        #1;
        ls2 = 1'b0;
        for (int r = 1; r <= 60; r++) begin
            @(negedge clk);
            if (dv2) begin
                if (n < 16) begin
                    want = 16'(n);
                    got = img2;
                end else if (n < 25) begin
                    want = 16'h1000 + 16'(n - 16);
                    got = wgt2;
                end else begin
                    want = 16'h2000 + 16'(n - 25);
                    got = bias2;
                end
                check("small_beat", {16'd0, got}, {16'd0, want});
                n++;
            end
            if (done2 && d2rel < 0) d2rel = r;
        end
        check("small_beats", n, 32'd26);
        check("small_done_rel", d2rel, 32'd29);
`ifdef CONV2_LOADER_CHECKSUM_EN
        check("small_checksum", checksum2, 32'd45212);
`endif
        $display("small load: beats=%0d done@%0d", n, d2rel);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/conv2_stream_loader.md
Name: conv2_stream_loader

Overview:
Transmit side of the conv2 input stream protocol.
- On a start request, issues a one-cycle start_conv2 pulse to conv_layer_2.
- Then streams the full input image, weights and biases from a shared synchronous-read parameter memory on partial_image_in, partial_weights_in and partial_biases_in, qualified by data_valid.
- Sits between the layer-1 output/parameter memory and conv_layer_2, replacing bench-driven stimulus in the integrated design.

Parameters:
- IN_CHANNELS, 2, input channel count
- OUT_CHANNELS, 3, output channel count
- IN_IMG_SIZE, 12, input image width/height
- KERNEL_SIZE, 3, kernel width/height
- DATA_WIDTH, 16, word width (signed)
- ADDR_WIDTH, 9, memory address width; must satisfy 2^ADDR_WIDTH >= max(TOTAL_PIXELS, TOTAL_WEIGHTS, TOTAL_BIASES)

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- load_start  in  1  request pulse; sampled only in IDLE
- hold  in  1  pause; blocks issue of new memory reads
- busy  out  1  high from the cycle after load_start is accepted through the load_done cycle
- load_done  out  1  one-cycle pulse after the last bias beat
- mem_rd_en  out  1  memory read strobe
- mem_sel  out  2  00 image, 01 weights, 10 biases
- mem_addr  out  ADDR_WIDTH  word address within the selected region
- mem_rd_data  in  DATA_WIDTH  read data, valid the cycle after mem_rd_en
- start_conv2  out  1  one-cycle start pulse to conv_layer_2
- data_valid  out  1  qualifies the partial_* words
- partial_image_in  out  DATA_WIDTH  image word
- partial_weights_in  out  DATA_WIDTH  weight word
- partial_biases_in  out  DATA_WIDTH  bias word

Behaviour:
- Totals:
  - TOTAL_PIXELS = IN_IMG_SIZE^2 * IN_CHANNELS (default 288)
  - TOTAL_WEIGHTS = KERNEL_SIZE^2 * IN_CHANNELS * OUT_CHANNELS (default 54)
  - TOTAL_BIASES = OUT_CHANNELS (default 3)
- Reset: every output is 0 and the FSM is in IDLE. Reset takes effect immediately, including mid-stream, and in-flight reads are discarded.
- FSM states: IDLE, START, IMG, WGT, BIAS, DRAIN, DONE.
- IDLE -> START when load_start=1 at edge k. load_start while busy is ignored.
- START (cycle k+1):
  - start_conv2=1, busy=1.
  - If hold=0: mem_rd_en=1, sel=00, addr=0.
  - Advance to IMG.
- IMG/WGT/BIAS:
  - Each cycle with hold=0: mem_rd_en=1 and the address increments.
  - At count-1 of the region, the next read moves to the next region at address 0.
  - After the last bias read, go to DRAIN.
  - hold=1: mem_rd_en=0 and the address/state are frozen.
- Data pipeline (2 stages):
  - Read issued in cycle t; memory data in cycle t+1; registered onto the partial_* port of its region with data_valid=1 in cycle t+2.
  - Region tag and valid are delayed alongside the data.
  - In-flight reads always complete, so data_valid falls 2 cycles after hold rises.
- Output hold: only the port of the active region updates. The other partial_* ports hold their last values, as do all ports when data_valid=0.
- Ordering: the stream is image[0..TOTAL_PIXELS-1], then weights[0..], then biases[0..], with no duplicate or skipped words. With hold=0 throughout, data_valid is continuous, 345 beats at defaults.
- DRAIN waits until the pipeline is empty. DONE then pulses load_done for one cycle and returns to IDLE, and busy drops the following cycle.
- Unhindered timing: start_conv2 at k+1, first beat at k+3, last beat at k+347, load_done at k+348.
- load_start in the load_done cycle is ignored. It is accepted in IDLE from k+349 on.

Optional Feature:
- Macro: CONV2_LOADER_CHECKSUM_EN.
- Defined:
  - Adds output checksum (32-bit).
  - Cleared to 0 in START.
  - Adds the sign-extended value of every transmitted beat, with wrap-around modulo 2^32.
  - Stable and valid from the load_done cycle until the next START; 0 after reset.
- Undefined: the port and accumulator are absent, and all other behaviour is identical.

Test Plan:
- Memory model returns image=addr, weights=0x1000+addr, biases=0x2000+addr.
- Reset, then load_start pulse:
  - start_conv2 is high for exactly 1 cycle.
  - 345 contiguous data_valid beats carry image 0x0000..0x011F, weights 0x1000..0x1035, biases 0x2000..0x2002.
  - load_done is a single pulse 348 cycles after the load_start edge.
- hold=1 for 5 cycles during image beat ~100:
  - Still exactly 345 beats, in order, with no duplicates.
  - data_valid gap of 5 cycles; load_done at k+353.
- load_start re-pulsed at k+50 and at k+200: ignored. A single sequence and a single load_done result.
- reset asserted during the weights phase:
  - All outputs are 0 in that cycle.
  - After deassertion, a new load_start replays the full sequence starting at image 0x0000.
- Params IN_CHANNELS=1, OUT_CHANNELS=1, IN_IMG_SIZE=4, KERNEL_SIZE=3: 16+9+1=26 beats, load_done at k+29.
- With CONV2_LOADER_CHECKSUM_EN, defaults: checksum = sum(0..287) + sum(0x1000..0x1035) + sum(0x2000..0x2002) = 41328 + 222615 + 24579 = 288522 (0x0004670A) at load_done.
